// File: rtl/sram_pixel_engine.sv
`default_nettype none
// ============================================================================
// sram_pixel_engine: 1bpp SRAM framebuffer controller (display fetch, plot, erase)
// Rev 1.0
// ============================================================================
module sram_pixel_engine #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 18,
  parameter int ERASE_LINE = 481
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcounter,
  input  logic [9:0]        vcounter,
  input  logic              erase_button,
  input  logic              plot_valid,
  input  logic [10:0]       plot_x,
  input  logic [9:0]        plot_y,
  output logic              plot_ready,
  input  logic              ready,
  output logic [ADDR_W-1:0] address,
  input  logic [WORD_W-1:0] data_read,
  output logic [WORD_W-1:0] data_write,
  output logic              read,
  output logic              write,
  output logic [WORD_W-1:0] pixel_buf,
  output logic              pixel_valid,
  output logic              erase_busy,
  output logic [3:0]        ram_state
);

  localparam int WPL       = H_VISIBLE / WORD_W;
  localparam int TOTAL     = WPL * V_VISIBLE;
  localparam int WORD_LOG2 = $clog2(WORD_W);

  localparam logic [10:0]       H_VIS_L   = 11'(H_VISIBLE);
  localparam logic [9:0]        V_VIS_L   = 10'(V_VISIBLE);
  localparam logic [9:0]        ERASE_L   = 10'(ERASE_LINE);
  localparam logic [ADDR_W-1:0] WPL_L     = ADDR_W'(WPL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH_REQ  = 4'd1,
    FETCH_STB  = 4'd2,
    FETCH_DATA = 4'd3,
    PLOT_REQ   = 4'd4,
    PLOT_STB   = 4'd5,
    PLOT_MOD   = 4'd6,
    PLOT_WR    = 4'd7,
    ERASE_WR   = 4'd8,
    ERASE_STB  = 4'd9,
    ERASE_NEXT = 4'd10
  } state_t;

  state_t              state_q, state_d;
  logic                fetch_pending_q, fetch_pending_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic                erase_pending_q, erase_pending_d;
  logic                erase_busy_q, erase_busy_d;
  logic [ADDR_W-1:0]   erase_ptr_q, erase_ptr_d;
  logic [10:0]         plot_x_q, plot_x_d;
  logic [9:0]          plot_y_q, plot_y_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [WORD_W-1:0]   data_write_q, data_write_d;
  logic [WORD_W-1:0]   pixel_buf_q, pixel_buf_d;
  logic                pixel_valid_q, pixel_valid_d;

  logic                fetch_trig, erase_trig, plot_oob;
  logic [ADDR_W-1:0]   fetch_addr_now, plot_addr;
  logic [WORD_W-1:0]   plot_mask;

  assign fetch_trig = (hcounter[WORD_LOG2-1:0] == '0) && (hcounter < H_VIS_L) &&
                      (vcounter < V_VIS_L);
  assign erase_trig = (hcounter == 11'd0) && (vcounter == ERASE_L) && erase_button &&
                      !erase_busy_q;
  assign plot_oob   = (plot_x >= H_VIS_L) || (plot_y >= V_VIS_L);

  assign fetch_addr_now = ADDR_W'(vcounter) * WPL_L + ADDR_W'(hcounter >> WORD_LOG2);
  assign plot_addr      = ADDR_W'(plot_y_q) * WPL_L + ADDR_W'(plot_x_q >> WORD_LOG2);
  assign plot_mask      = WORD_W'(1) << plot_x_q[WORD_LOG2-1:0];

  always_comb begin
    state_d         = state_q;
    fetch_pending_d = fetch_pending_q;
    fetch_addr_d    = fetch_addr_q;
    erase_pending_d = erase_pending_q;
    erase_busy_d    = erase_busy_q;
    erase_ptr_d     = erase_ptr_q;
    plot_x_d        = plot_x_q;
    plot_y_d        = plot_y_q;
    address_d       = address_q;
    data_write_d    = data_write_q;
    pixel_buf_d     = pixel_buf_q;
    pixel_valid_d   = 1'b0;
    read            = 1'b0;
    write           = 1'b0;
    plot_ready      = (state_q == IDLE) && !fetch_pending_q && !erase_busy_q &&
                      (vcounter >= V_VIS_L);

    case (state_q)
      IDLE: begin
        if (fetch_pending_q) begin
          state_d = FETCH_REQ;
        end else if (erase_pending_q) begin
          state_d = ERASE_WR;
        end else if (plot_valid && plot_ready && !plot_oob) begin
          plot_x_d = plot_x;
          plot_y_d = plot_y;
          state_d  = PLOT_REQ;
        end
      end
      FETCH_REQ: if (ready) begin
        address_d = fetch_addr_q;
        state_d   = FETCH_STB;
      end
      FETCH_STB: begin
        read    = 1'b1;
        state_d = FETCH_DATA;
      end
      FETCH_DATA: begin
        pixel_buf_d     = data_read;
        pixel_valid_d   = 1'b1;
        fetch_pending_d = 1'b0;
        state_d         = IDLE;
      end
      PLOT_REQ: if (ready) begin
        address_d = plot_addr;
        state_d   = PLOT_STB;
      end
      PLOT_STB: begin
        read    = 1'b1;
        state_d = PLOT_MOD;
      end
      PLOT_MOD: begin
        data_write_d = data_read | plot_mask;
        state_d      = PLOT_WR;
      end
      PLOT_WR: if (ready) begin
        write   = 1'b1;
        state_d = IDLE;
      end
      ERASE_WR: if (ready) begin
        address_d    = erase_ptr_q;
        data_write_d = '0;
        state_d      = ERASE_STB;
      end
      ERASE_STB: begin
        write       = 1'b1;
        erase_ptr_d = erase_ptr_q + 1'b1;
        if (erase_ptr_q == LAST_ADDR) begin
          erase_busy_d    = 1'b0;
          erase_pending_d = 1'b0;
          state_d         = IDLE;
        end else begin
          state_d = ERASE_NEXT;
        end
      end
      // Passing back through IDLE lets a pending display fetch cut in.
      ERASE_NEXT: state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    // A new trigger outranks the clear in FETCH_DATA so it is never lost.
    if (fetch_trig) begin
      fetch_pending_d = 1'b1;
      fetch_addr_d    = fetch_addr_now;
    end
    if (erase_trig) begin
      erase_pending_d = 1'b1;
      erase_busy_d    = 1'b1;
      erase_ptr_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      fetch_pending_q <= 1'b0;
      fetch_addr_q    <= '0;
      erase_pending_q <= 1'b0;
      erase_busy_q    <= 1'b0;
      erase_ptr_q     <= '0;
      plot_x_q        <= '0;
      plot_y_q        <= '0;
      address_q       <= '0;
      data_write_q    <= '0;
      pixel_buf_q     <= '0;
      pixel_valid_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pending_q <= fetch_pending_d;
      fetch_addr_q    <= fetch_addr_d;
      erase_pending_q <= erase_pending_d;
      erase_busy_q    <= erase_busy_d;
      erase_ptr_q     <= erase_ptr_d;
      plot_x_q        <= plot_x_d;
      plot_y_q        <= plot_y_d;
      address_q       <= address_d;
      data_write_q    <= data_write_d;
      pixel_buf_q     <= pixel_buf_d;
      pixel_valid_q   <= pixel_valid_d;
    end
  end

  assign address     = address_q;
  assign data_write  = data_write_q;
  assign pixel_buf   = pixel_buf_q;
  assign pixel_valid = pixel_valid_q;
  assign erase_busy  = erase_busy_q;
  assign ram_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_pixel_engine.sv
`default_nettype none
// ============================================================================
// tb_sram_pixel_engine: scoreboard bench with an SRAM model for sram_pixel_engine
// Rev 1.0
// ============================================================================
module tb_sram_pixel_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcounter;
  logic [9:0]  vcounter;
  logic        erase_button, plot_valid, ready;
  logic [10:0] plot_x;
  logic [9:0]  plot_y;
  logic        plot_ready, read, write, pixel_valid, erase_busy;
  logic [17:0] address;
  logic [15:0] data_read, data_write, pixel_buf;
  logic [3:0]  ram_state;

  always #5 clk = ~clk;

  sram_pixel_engine dut (
    .clk(clk), .reset(reset), .hcounter(hcounter), .vcounter(vcounter),
    .erase_button(erase_button), .plot_valid(plot_valid), .plot_x(plot_x),
    .plot_y(plot_y), .plot_ready(plot_ready), .ready(ready), .address(address),
    .data_read(data_read), .data_write(data_write), .read(read), .write(write),
    .pixel_buf(pixel_buf), .pixel_valid(pixel_valid), .erase_busy(erase_busy),
    .ram_state(ram_state)
  );

  // SRAM model with a backdoor write port for preloading
  logic [15:0] mem [0:262143];
  logic        bd_we = 1'b0;
  logic [17:0] bd_addr;
  logic [15:0] bd_data;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (read)  data_read <= mem[address];
    if (write) mem[address] <= data_write;
  end

  typedef struct packed { logic [17:0] a; logic [15:0] d; } wr_t;
  logic [17:0] rq [$];
  logic [15:0] pq [$];
  wr_t         wq [$];

  int n_checks = 0, n_fail = 0, n_reads = 0, n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or a pixel word
  always @(negedge clk) begin : monitor
    logic [17:0] ea;
    logic [15:0] ed;
    wr_t         ew;
    if (read && write) check("strobe_overlap", 1, 0);
    if (read) begin
      n_reads++;
      if (rq.size() == 0) check("unexpected_read", address, 18'h3ffff);
      else begin
        ea = rq.pop_front();
        check("read_addr", address, ea);
      end
    end
    if (write) begin
      n_writes++;
      if (wq.size() == 0) check("unexpected_write", address, 18'h3ffff);
      else begin
        ew = wq.pop_front();
        check("write_addr", address, ew.a);
        check("write_data", data_write, ew.d);
      end
    end
    if (pixel_valid) begin
      if (pq.size() == 0) check("unexpected_pixel", pixel_buf, 16'hxxxx);
      else begin
        ed = pq.pop_front();
        check("pixel_buf", pixel_buf, ed);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [17:0] a, input logic [15:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    tick(1);
    bd_we = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while ((rq.size() + pq.size() + wq.size()) != 0 && k < max) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_remaining", rq.size() + pq.size() + wq.size(), 0);
  endtask

  task automatic fetch_pulse(input logic [10:0] h, input logic [9:0] v);
    hcounter = h; vcounter = v;
    tick(1);
    hcounter = h + 11'd1;
  endtask

  task automatic do_plot(input logic [10:0] x, input logic [9:0] y, output logic acc);
    int k = 0;
    plot_x = x; plot_y = y; plot_valid = 1'b1; acc = 1'b0;
    while (!acc && k < 50) begin
      @(negedge clk);
      acc = plot_ready;
      k++;
    end
    tick(1);
    plot_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"}, address, 0);
    check({tag, "_data_write"}, data_write, 0);
    check({tag, "_read"}, read, 0);
    check({tag, "_write"}, write, 0);
    check({tag, "_pixel_buf"}, pixel_buf, 0);
    check({tag, "_pixel_valid"}, pixel_valid, 0);
    check({tag, "_erase_busy"}, erase_busy, 0);
    check({tag, "_ram_state"}, ram_state, 0);
    check({tag, "_plot_ready"}, plot_ready, 0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic acc, seen;
    int   r0, w0, k;

    reset = 1'b1; hcounter = 11'd1; vcounter = 10'd0; erase_button = 1'b0;
    plot_valid = 1'b0; plot_x = '0; plot_y = '0; ready = 1'b1;
    tick(2);
    poke(18'd41, 16'hA5A5);
    poke(18'd80, 16'h0100);
    poke(18'd82, 16'h5A5A);
    poke(18'd19199, 16'h1234);
    poke(18'd19200, 16'hBEEF);
    reset = 1'b0;
    check_reset_outputs("reset");

    // Display fetch: line 1, column 16 -> word 41
    rq.push_back(18'd41); pq.push_back(16'hA5A5);
    fetch_pulse(11'd16, 10'd1);
    wait_drain(20);
    check("pixel_valid_single", pixel_valid, 0);

    // Plot RMW in vblank: (19,1) -> word 41 bit 3
    vcounter = 10'd500; hcounter = 11'd1;
    poke(18'd41, 16'h0001);
    rq.push_back(18'd41); wq.push_back('{a: 18'd41, d: 16'h0009});
    do_plot(11'd19, 10'd1, acc);
    check("plot_accept", acc, 1);
    @(negedge clk);
    check("plot_ready_one_cycle", plot_ready, 0);
    tick(1);
    wait_drain(30);
    check("mem41_after_plot", mem[41], 16'h0009);

    // Plot gating during the visible area
    vcounter = 10'd100; hcounter = 11'd5;
    plot_x = 11'd3; plot_y = 10'd3; plot_valid = 1'b1; seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | plot_ready;
    end
    tick(1);
    plot_valid = 1'b0;
    check("plot_gated_visible", seen, 0);

    // Out-of-range plot: accepted, no SRAM access
    vcounter = 10'd500; hcounter = 11'd1;
    r0 = n_reads; w0 = n_writes;
    do_plot(11'd700, 10'd3, acc);
    check("oob_plot_accept", acc, 1);
    tick(20);
    check("oob_no_reads", n_reads, r0);
    check("oob_no_writes", n_writes, w0);
    check("oob_idle", ram_state, 0);

    // ready held low during FETCH_REQ
    ready = 1'b0;
    r0 = n_reads;
    rq.push_back(18'd82); pq.push_back(16'h5A5A);
    fetch_pulse(11'd32, 10'd2);
    vcounter = 10'd500; hcounter = 11'd1;
    tick(10);
    check("fetch_stall_no_read", n_reads, r0);
    check("fetch_stall_state", ram_state, 1);
    ready = 1'b1;
    wait_drain(20);

    // ready held low during PLOT_WR: (5,2) -> word 80 bit 5
    rq.push_back(18'd80); wq.push_back('{a: 18'd80, d: 16'h0120});
    do_plot(11'd5, 10'd2, acc);
    check("plot2_accept", acc, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ram_state != 4'd6 && k < 10);
    ready = 1'b0;
    w0 = n_writes;
    repeat (10) @(negedge clk);
    check("plotwr_stall_no_write", n_writes, w0);
    check("plotwr_stall_state", ram_state, 7);
    ready = 1'b1;
    tick(1);
    wait_drain(20);
    check("mem80_after_plot", mem[80], 16'h0120);

    // Full erase, with a repeated button press and display fetches cutting in
    for (int i = 0; i < 19200; i++) wq.push_back('{a: 18'(i), d: 16'h0000});
    w0 = n_writes;
    erase_button = 1'b1; hcounter = 11'd0; vcounter = 10'd481;
    tick(1);
    hcounter = 11'd1; vcounter = 10'd500;
    check("erase_busy_rise", erase_busy, 1);
    k = 0;
    while (n_writes - w0 < 100 && k < 1000) begin
      tick(1);
      k++;
    end
    hcounter = 11'd0; vcounter = 10'd481;
    tick(1);
    hcounter = 11'd1; vcounter = 10'd500;
    tick(3);
    rq.push_back(18'd0); pq.push_back(16'h0000);
    hcounter = 11'd0; vcounter = 10'd0;
    tick(1);
    hcounter = 11'd1; vcounter = 10'd500;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!read && k < 8);
    check("preempt_fetch_latency_ok", (k <= 5), 1);
    tick(1);
    rq.push_back(18'd19199); pq.push_back(16'h1234);
    fetch_pulse(11'd624, 10'd479);
    hcounter = 11'd1; vcounter = 10'd500;
    k = 0;
    while (erase_busy && k < 90000) begin
      tick(1);
      k++;
    end
    erase_button = 1'b0;
    check("erase_busy_fall", erase_busy, 0);
    check("erase_write_count", n_writes - w0, 19200);
    wait_drain(20);
    check("mem19199_erased", mem[19199], 16'h0000);
    check("mem19200_untouched", mem[19200], 16'hBEEF);

    // Reset in the middle of an erase
    for (int i = 0; i < 300; i++) wq.push_back('{a: 18'(i), d: 16'h0000});
    w0 = n_writes;
    erase_button = 1'b1; hcounter = 11'd0; vcounter = 10'd481;
    tick(1);
    erase_button = 1'b0; hcounter = 11'd1; vcounter = 10'd500;
    k = 0;
    while (n_writes - w0 < 50 && k < 1000) begin
      tick(1);
      k++;
    end
    vcounter = 10'd0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wq.delete();
    check_reset_outputs("midreset");
    r0 = n_reads; w0 = n_writes;
    tick(20);
    check("post_reset_no_reads", n_reads, r0);
    check("post_reset_no_writes", n_writes, w0);
    check("post_reset_idle", ram_state, 0);

    check("final_queues_empty", rq.size() + pq.size() + wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
